// File: rtl/if_id_fetch_stage.sv
// Fetch stage with IF/ID pipeline register: owns the PC, issues imem reads,
// applies HDU stall/flush, halts on HLT and counts bubble cycles.
module if_id_fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INST   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_flush,
  input  logic [15:0]      br_target,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_valid,
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  output logic [15:0]      if_id_inst,
  output logic [15:0]      if_id_pc_plus2,
  output logic             if_id_valid,
  output logic             fetch_halted,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [15:0] pc_plus2;
  logic [15:0] inst_nxt;
  logic [15:0] pcp2_nxt;
  logic        valid_nxt;
  logic        load_nop;

  assign pc_plus2     = pc + 16'd2;
  assign imem_addr    = pc;
  assign imem_req     = (state == FETCH);
  assign fetch_halted = (state == HALT);

  // Per-edge priority: flush, then stall, then fetch/wait/halt handling.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = if_id_inst;
    pcp2_nxt  = if_id_pc_plus2;
    valid_nxt = if_id_valid;
    load_nop  = 1'b0;
    if (if_flush) begin
      pc_nxt    = br_target;
      state_nxt = FETCH;
      load_nop  = 1'b1;
    end else if (!stall) begin
      if (state == FETCH && imem_valid) begin
        inst_nxt  = imem_rdata;
        pcp2_nxt  = pc_plus2;
        valid_nxt = 1'b1;
        if (imem_rdata[15:12] == HLT_OPCODE) begin
          state_nxt = HALT;
        end else begin
          pc_nxt = pc_plus2;
        end
      end else begin
        load_nop = 1'b1;
      end
    end
    if (load_nop) begin
      inst_nxt  = NOP_INST;
      pcp2_nxt  = 16'h0000;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      if_id_inst     <= NOP_INST;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else begin
      pc             <= pc_nxt;
      if_id_inst     <= inst_nxt;
      if_id_pc_plus2 <= pcp2_nxt;
      if_id_valid    <= valid_nxt;
    end
  end

  // Saturating bubble counter; stall never loads a bubble so it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (load_nop && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: a behavioural model pushes expected
// IF/ID state per edge, compared after each rising edge.
module tb_if_id_fetch_stage;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             if_flush;
  logic [15:0]      br_target;
  logic [15:0]      imem_rdata;
  logic             imem_valid;
  logic             imem_req;
  logic [15:0]      imem_addr;
  logic [15:0]      if_id_inst;
  logic [15:0]      if_id_pc_plus2;
  logic             if_id_valid;
  logic             fetch_halted;
  logic [CNT_W-1:0] bubble_cnt;

  logic [15:0] mem [256];
  assign imem_rdata = mem[imem_addr[8:1]];

  if_id_fetch_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_flush(if_flush),
    .br_target(br_target), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .if_id_inst(if_id_inst),
    .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid),
    .fetch_halted(fetch_halted), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      pc;
    logic [15:0]      inst;
    logic [15:0]      pcp2;
    logic             valid;
    logic             halt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0]      m_pc;
  logic [15:0]      m_inst;
  logic [15:0]      m_pcp2;
  logic             m_valid;
  logic             m_halt;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_inst = 16'h0000; m_pcp2 = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0; m_cnt = '0;
  endtask

  task automatic bubble();
    m_inst = 16'h0000; m_pcp2 = 16'h0000; m_valid = 1'b0;
    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic compare_now(input string tag, input exp_t e);
    check({tag, "_pc"}, 32'(imem_addr), 32'(e.pc));
    check({tag, "_inst"}, 32'(if_id_inst), 32'(e.inst));
    check({tag, "_valid"}, 32'(if_id_valid), 32'(e.valid));
    if (e.valid) check({tag, "_pcp2"}, 32'(if_id_pc_plus2), 32'(e.pcp2));
    check({tag, "_halt"}, 32'(fetch_halted), 32'(e.halt));
    check({tag, "_req"}, 32'(imem_req), 32'(!e.halt));
    check({tag, "_cnt"}, 32'(bubble_cnt), 32'(e.cnt));
  endtask

  // Drive one cycle of stimulus, predict the edge, then compare after it.
  task automatic step(input string tag, input logic st, input logic fl,
                      input logic [15:0] tgt, input logic v);
    logic [15:0] w;
    exp_t e;
    stall = st; if_flush = fl; br_target = tgt; imem_valid = v;
    if (fl) begin
      m_pc = tgt; m_halt = 1'b0; bubble();
    end else if (!st) begin
      if (!m_halt && v) begin
        w = mem[m_pc[8:1]];
        m_inst = w; m_pcp2 = m_pc + 16'd2; m_valid = 1'b1;
        if (w[15:12] == 4'hF) m_halt = 1'b1;
        else m_pc = m_pc + 16'd2;
      end else begin
        bubble();
      end
    end
    sb.push_back('{m_pc, m_inst, m_pcp2, m_valid, m_halt, m_cnt});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      compare_now(tag, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[4] = 16'hF000;
    rst = 1'b1; stall = 1'b0; if_flush = 1'b0; br_target = 16'h0000; imem_valid = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_now("reset", '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, '0});
    rst = 1'b0;

    // T1 sequential fetch
    step("t1_a", 0, 0, 16'h0, 1);
    check("t1_pcp2_2", 32'(if_id_pc_plus2), 32'h2);
    step("t1_b", 0, 0, 16'h0, 1);
    // T2 stall at pc=4
    step("t2_s1", 1, 0, 16'h0, 1);
    step("t2_s2", 1, 0, 16'h0, 1);
    check("t2_hold_inst", 32'(if_id_inst), 32'h1001);
    step("t2_resume", 0, 0, 16'h0, 1);
    check("t2_word4", 32'(if_id_inst), 32'h1002);
    // T5 memory wait at pc=6
    for (int i = 0; i < 3; i++) step("t5_wait", 0, 0, 16'h0, 0);
    check("t5_cnt3", 32'(bubble_cnt), 32'd3);
    check("t5_pc6", 32'(imem_addr), 32'h6);
    step("t5_word6", 0, 0, 16'h0, 1);
    // T4 HLT at pc=8, then stalled and unstalled halt cycles
    step("t4_hlt", 0, 0, 16'h0, 1);
    check("t4_halted", 32'(fetch_halted), 32'd1);
    step("t4_hstall", 1, 0, 16'h0, 1);
    step("t4_hbub", 0, 0, 16'h0, 1);
    step("t4_flush", 0, 1, 16'h0010, 1);
    check("t4_redirect", 32'(imem_addr), 32'h0010);
    step("t4_f10", 0, 0, 16'h0, 1);
    // T3 flush beats stall
    step("t3_flush", 1, 1, 16'h0040, 1);
    check("t3_pc40", 32'(imem_addr), 32'h0040);
    step("t3_f40", 0, 0, 16'h0, 1);
    // PC wrap-around
    step("wrap_flush", 0, 1, 16'hFFFE, 1);
    step("wrap_fetch", 0, 0, 16'h0, 1);
    check("wrap_pcp2", 32'(if_id_pc_plus2), 32'h0000);
    // Counter saturation
    for (int i = 0; i < 18; i++) step("sat", 0, 0, 16'h0, 0);
    check("sat_max", 32'(bubble_cnt), 32'hF);
    // T6 async reset mid-wait
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_now("t6_wait_rst", '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, '0});
    @(posedge clk);
    #1 rst = 1'b0;
    step("t6_restart", 0, 0, 16'h0, 1);
    step("t6_to8", 0, 1, 16'h0008, 1);
    step("t6_hlt", 0, 0, 16'h0, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_now("t6_halt_rst", '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, '0});
    @(posedge clk);
    #1 rst = 1'b0;
    step("t6_restart2", 0, 0, 16'h0, 1);
    check("t6_pc2", 32'(imem_addr), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
